// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit resolved per clock through
// a single full-subtractor cell, with valid/ready handshakes on both sides.
// Optional build macro SERIAL_SUB_OVERFLOW_FLAG_EN adds the signed-overflow output V.
module serial_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
  output logic             V,
`endif
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
  logic             v_q, v_d;
`endif

  logic             d_bit;
  logic             borrow_nxt;

  function automatic logic fs_diff(input logic a, input logic b, input logic bi);
    return a ^ b ^ bi;
  endfunction

  function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
    return (~a & b) | (~(a ^ b) & bi);
  endfunction

  // New result bit enters from the MSB side so the LSB lands at bit 0 after WIDTH steps.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r, input logic d);
    return WIDTH'({d, r} >> 1);
  endfunction

  // Next-state and datapath: one full-subtractor step per SHIFT cycle.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    borrow_d   = borrow_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
    v_d        = v_q;
`endif
    d_bit      = fs_diff(a_q[0], b_q[0], borrow_q);
    borrow_nxt = fs_borrow(a_q[0], b_q[0], borrow_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          cnt_d    = '0;
          res_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = shift_in(res_q, d_bit);
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          diff_d  = shift_in(res_q, d_bit);
          bout_d  = borrow_nxt;
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
          // Borrow into the MSB differs from borrow out of it exactly on signed overflow.
          v_d     = borrow_q ^ borrow_nxt;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
      v_q         <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
      v_q         <= v_d;
`endif
    end
  end

  assign Diff      = diff_q;
  assign Bout      = bout_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
  assign V         = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=6): stimulus pushes expected
// results, a negedge monitor pops and compares on every result handshake.
module tb_serial_subtractor;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         busy;
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
  logic         V;
`endif

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         v;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Bout      (Bout),
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
    .V         (V),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle of every accepted operand set.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: compare every result that the consumer actually takes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(Diff), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_diff"}, 64'(Diff), 64'(e.diff));
        chk({e.name, "_bout"}, 64'(Bout), 64'(e.bout));
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
        chk({e.name, "_v"}, 64'(V), 64'(e.v));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic bo, input logic v, input string nm);
    exp_t e;
    e.diff = d; e.bout = bo; e.v = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Issue one operation with out_ready=1 and check latency and handshake timing.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic [W-1:0] ed, input logic eb, input logic ev, input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk({nm, "_ready_wait"}, 64'(in_ready), 64'd1);
    A = a; B = b; Bin = bi; in_valid = 1'b1;
    push_exp(ed, eb, ev, nm);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk({nm, "_latency"}, 64'(n), 64'(W));
    tick();
    chk({nm, "_valid_one_cycle"}, 64'(out_valid), 64'd0);
    chk({nm, "_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a0;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_diff", 64'(Diff), 64'd0);
    chk("rst_bout", 64'(Bout), 64'd0);
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
    chk("rst_v", 64'(V), 64'd0);
`endif

    // Basic and boundary vectors
    run_op(6'd20, 6'd7,  1'b0, 6'd13, 1'b0, 1'b0, "t1_20m7");
    run_op(6'd5,  6'd9,  1'b0, 6'd60, 1'b1, 1'b0, "t2_5m9");
    run_op(6'd0,  6'd0,  1'b1, 6'd63, 1'b1, 1'b0, "t2_0m0m1");
    run_op(6'd63, 6'd63, 1'b0, 6'd0,  1'b0, 1'b0, "t2_63m63");

    // Backpressure with noisy inputs while DONE
    out_ready = 1'b0;
    A = 6'd40; B = 6'd8; Bin = 1'b0; in_valid = 1'b1;
    push_exp(6'd32, 1'b0, 1'b0, "t3_40m8");
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("t3_latency", 64'(n), 64'(W));
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      A = 6'(i * 13 + 1); B = 6'(i * 7 + 3);
      tick();
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_diff", 64'(Diff), 64'd32);
      chk("t3_hold_bout", 64'(Bout), 64'd0);
      chk("t3_no_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t3_released_ready", 64'(in_ready), 64'd1);
    chk("t3_released_valid", 64'(out_valid), 64'd0);
    tick();
    chk("t3_no_second_accept", 64'(busy), 64'd0);

    // Reset during the third SHIFT cycle discards the operation
    A = 6'd50; B = 6'd7; Bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("t4_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_diff", 64'(Diff), 64'd0);
    chk("t4_bout", 64'(Bout), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    run_op(6'd33, 6'd1, 1'b0, 6'd32, 1'b0, 1'b0, "t4_33m1");

    // Back-to-back with in_valid held high
    acc_q.delete();
    A = 6'd10; B = 6'd3; Bin = 1'b0; in_valid = 1'b1;
    push_exp(6'd7, 1'b0, 1'b0, "t5_10m3");
    tick();
    chk("t5_first_accept", 64'(acc_q.size()), 64'd1);
    A = 6'd3; B = 6'd10;
    push_exp(6'd57, 1'b1, 1'b0, "t5_3m10");
    n = 0;
    while (acc_q.size() < 2 && n < 50) begin tick(); n++; end
    in_valid = 1'b0;
    chk("t5_second_accept", 64'(acc_q.size()), 64'd2);
    if (acc_q.size() == 2) begin
      a0 = acc_q[1] - acc_q[0];
      chk("t5_issue_interval", 64'(a0), 64'(W + 2));
    end
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("t5_drain", 64'(in_ready), 64'd1);

    // Signed overflow vectors
    run_op(6'd32, 6'd1,  1'b0, 6'd31, 1'b0, 1'b1, "t6_32m1");
    run_op(6'd31, 6'd63, 1'b0, 6'd32, 1'b1, 1'b1, "t6_31m63");
    run_op(6'd5,  6'd3,  1'b0, 6'd2,  1'b0, 1'b0, "t6_5m3");

    tick(); tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
